// File: rtl/md_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | md_pkg: op codes and op-class helpers for the multiply/divide unit    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;
  localparam logic [2:0] MD_MADD  = 3'b110;
  localparam logic [2:0] MD_MSUB  = 3'b111;

  // What the unit does to HI/LO when the latency timer expires.
  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_LOAD = 2'd1,
    PEND_ADD  = 2'd2,
    PEND_SUB  = 2'd3
  } md_pend_e;

  function automatic logic is_mult(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_mt(input logic [2:0] op);
    return (op == MD_MTHI) || (op == MD_MTLO);
  endfunction

  function automatic logic is_acc(input logic [2:0] op);
    return (op == MD_MADD) || (op == MD_MSUB);
  endfunction

endpackage
`default_nettype wire

// File: rtl/md_latency_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | md_latency_timer: loadable down-counter giving busy and done strobe   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module md_latency_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          busy_o,
  output logic          done_o
);

  logic [CW-1:0] count_q, count_d;
  logic          busy_q, busy_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - CW'(1);
    end
    busy_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

  // High during the cycle whose closing edge takes the count 1 -> 0.
  assign done_o = (count_q == CW'(1));
  assign busy_o = busy_q;

endmodule
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | md_unit: multi-cycle multiply/divide unit with HI/LO registers        |
// | Optional accumulate ops (MADD/MSUB) enabled by macro MD_UNIT_ACC_EN   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_LAT + 1);
  localparam logic [CW-1:0] MULT_LAT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LAT  = CW'(DIV_CYCLES);

  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] pend_q, pend_d;
  md_pend_e           kind_q, kind_d;

  logic               accept;
  logic               timer_load;
  logic [CW-1:0]      timer_val;
  logic               timer_done;
  logic               timer_busy;

  assign accept = start & ~flush & ~timer_busy;

  md_latency_timer #(
    .CW (CW)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .busy_o     (timer_busy),
    .done_o     (timer_done)
  );

  // Products: sign-extending to 2*WIDTH makes the low 2*WIDTH bits the signed product.
  logic [2*WIDTH-1:0] a_sx, b_sx, prod_s, prod_u;
  assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  // Signed division via magnitudes; MIN/-1 falls out as MIN with zero remainder.
  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag, den_s, den_u;
  logic [WIDTH-1:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
  assign a_neg  = a[WIDTH-1];
  assign b_neg  = b[WIDTH-1];
  assign b_zero = (b == '0);
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;
  assign den_s  = b_zero ? WIDTH'(1) : b_mag;
  assign den_u  = b_zero ? WIDTH'(1) : b;
  assign q_mag  = a_mag / den_s;
  assign r_mag  = a_mag % den_s;
  assign q_s    = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign r_s    = a_neg ? -r_mag : r_mag;
  assign q_u    = a / den_u;
  assign r_u    = a % den_u;

`ifdef MD_UNIT_ACC_EN
  logic [2*WIDTH-1:0] acc_res;
  assign acc_res = (kind_q == PEND_SUB) ? ({hi_q, lo_q} - pend_q)
                                        : ({hi_q, lo_q} + pend_q);
`endif

  always_comb begin
    hi_d       = hi_q;
    lo_d       = lo_q;
    pend_d     = pend_q;
    kind_d     = kind_q;
    timer_load = 1'b0;
    timer_val  = '0;

    if (timer_done) begin
      case (kind_q)
        PEND_LOAD: {hi_d, lo_d} = pend_q;
`ifdef MD_UNIT_ACC_EN
        PEND_ADD,
        PEND_SUB:  {hi_d, lo_d} = acc_res;
`endif
        default: ;
      endcase
      kind_d = PEND_NONE;
    end

    if (accept) begin
      if (is_mult(op)) begin
        pend_d     = op[0] ? prod_u : prod_s;
        kind_d     = PEND_LOAD;
        timer_load = 1'b1;
        timer_val  = MULT_LAT;
      end else if (is_div(op)) begin
        pend_d     = op[0] ? {r_u, q_u} : {r_s, q_s};
        kind_d     = b_zero ? PEND_NONE : PEND_LOAD;
        timer_load = 1'b1;
        timer_val  = DIV_LAT;
      end else if (is_mt(op)) begin
        if (op[0]) lo_d = a;
        else       hi_d = a;
`ifdef MD_UNIT_ACC_EN
      end else if (is_acc(op)) begin
        pend_d     = prod_s;
        kind_d     = op[0] ? PEND_SUB : PEND_ADD;
        timer_load = 1'b1;
        timer_val  = MULT_LAT;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      pend_q <= '0;
      kind_q <= PEND_NONE;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      pend_q <= pend_d;
      kind_q <= kind_d;
    end
  end

  assign busy = timer_busy;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_md_unit: directed scoreboard bench for md_unit (32-bit, 5/10 lat)  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] ta = '0;
  logic [31:0] tb = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  md_unit #(
    .WIDTH       (32),
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .start (start),
    .op    (op),
    .a     (ta),
    .b     (tb),
    .flush (flush),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] busy_n;
  } exp_t;

  exp_t exp_q[$];
  int   req_cnt  = 0;
  int   served   = 0;
  int   busy_cnt = 0;
  int   total    = 0;
  int   bad      = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: pops one expectation per check request, then tracks busy cycles.
  always @(negedge clk) begin
    if (served != req_cnt) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard: check requested with empty queue");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        cmp("hi", hi, e.hi);
        cmp("lo", lo, e.lo);
        cmp("busy_cycles", busy_cnt, e.busy_n);
        cmp("busy_now", {31'd0, busy}, 32'd0);
      end
      served++;
      busy_cnt = 0;
    end
    if (busy) busy_cnt++;
  end

  task automatic expect_state(input logic [31:0] eh, input logic [31:0] el, input int eb);
    exp_t e;
    e.hi = eh;
    e.lo = el;
    e.busy_n = eb;
    exp_q.push_back(e);
    #1 req_cnt++;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic fl);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    ta    = x;
    tb    = y;
    flush = fl;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    wait_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    expect_state(32'h0, 32'h0, 0);

    issue(MD_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    expect_state(32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
    expect_state(32'h0000_0001, 32'hFFFF_FFFE, 5);

    issue(MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    expect_state(32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    issue(MD_DIVU, 32'd7, 32'd2, 1'b0);
    expect_state(32'd1, 32'd3, 10);
    issue(MD_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
    expect_state(32'd1, 32'hFFFF_FFFD, 10);
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    expect_state(32'h0, 32'h8000_0000, 10);

    issue(MD_MTHI, 32'd5, 32'd0, 1'b0);
    expect_state(32'd5, 32'h8000_0000, 0);
    issue(MD_MTLO, 32'h1234, 32'd0, 1'b0);
    expect_state(32'd5, 32'h1234, 0);
    issue(MD_DIVU, 32'd9, 32'd0, 1'b0);
    expect_state(32'd5, 32'h1234, 10);

    // Start during busy must be ignored.
    @(negedge clk);
    start = 1'b1; op = MD_MULT; ta = 32'h0001_0000; tb = 32'h0001_0000;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op = MD_MTHI; ta = 32'hDEAD;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    expect_state(32'd1, 32'd0, 5);

    issue(MD_MTLO, 32'hBEEF, 32'd0, 1'b1);
    expect_state(32'd1, 32'd0, 0);
    issue(MD_MULT, 32'd3, 32'd3, 1'b1);
    expect_state(32'd1, 32'd0, 0);

    issue(MD_MTHI, 32'd0, 32'd0, 1'b0);
    issue(MD_MTLO, 32'd10, 32'd0, 1'b0);
    expect_state(32'd0, 32'd10, 0);
    issue(MD_MADD, 32'd3, 32'd4, 1'b0);
`ifdef MD_UNIT_ACC_EN
    expect_state(32'd0, 32'd22, 5);
`else
    expect_state(32'd0, 32'd10, 0);
`endif
    issue(MD_MSUB, 32'hFFFF_FFFF, 32'd30, 1'b0);
`ifdef MD_UNIT_ACC_EN
    expect_state(32'd0, 32'd52, 5);
`else
    expect_state(32'd0, 32'd10, 0);
`endif

    // Asynchronous reset in the third busy cycle of a DIV.
    @(negedge clk);
    start = 1'b1; op = MD_DIV; ta = 32'd100; tb = 32'd7;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    expect_state(32'd0, 32'd0, 2);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    expect_state(32'd0, 32'd0, 0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits in the EX stage beside the ALU. Operands come from the forwarded EX operand muxes.
- The hazard controller stalls D on mfhi/mflo/md-class instructions while `start | busy`.
- Next generation of the datapath: configurable width and per-operation latency, and a true multi-cycle busy handshake that the current single-cycle EX stage does not have.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, cycles from accepted mult start to HI/LO update; must be >= 1.
- DIV_CYCLES, 10, cycles from accepted div start to HI/LO update; must be >= 1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request pulse from EX; qualified by `op`.
- op  in  3  operation code (md_pkg).
- a  in  WIDTH  operand A (rs, forwarded).
- b  in  WIDTH  operand B (rt, forwarded).
- flush  in  1  kill from EX clear; suppresses an accepted start in the same cycle.
- busy  out  1  operation in flight.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset == 0, asynchronous): `hi`=0, `lo`=0, `busy`=0, latency counter=0, pending result=0.
  - Reset mid-operation aborts it; HI/LO stay 0 and are not later updated.
- Accept condition: `start & ~flush & ~busy`. A `start` while `busy`=1 is ignored (hazard unit guarantees this never happens in normal flow); HI/LO and the in-flight op are unaffected.
- Op codes:
  - 000 MULT
  - 001 MULTU
  - 010 DIV
  - 011 DIVU
  - 100 MTHI
  - 101 MTLO
  - 110 MADD, 111 MSUB (only with the optional feature; otherwise treated as no-op)
- MTHI/MTLO:
  - `hi` (resp. `lo`) <= `a` at the accepting edge.
  - `busy` stays 0 (zero latency).
- MULT/MULTU:
  - Full 2*WIDTH product, signed/unsigned; {hi,lo} = product.
  - Result is captured at the accepting edge into the pending register.
  - `busy`=1 from that edge. HI/LO are written and `busy` drops at the MULT_CYCLES-th following edge, so `busy` is high for exactly MULT_CYCLES cycles.
- DIV/DIVU:
  - `lo` = quotient truncated toward zero; `hi` = remainder with the sign of the dividend.
  - Latency DIV_CYCLES, same timing as MULT.
  - Signed MIN / -1: `lo` = MIN, `hi` = 0 (two's-complement wrap).
  - Divide by zero: `busy` still asserts for DIV_CYCLES; HI/LO are left unchanged at completion.
- Counter:
  - Width $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
  - Loaded with the latency on accept; decrements while nonzero.
  - `busy` = (counter != 0), registered.
  - Commit on the edge where counter goes 1 -> 0.
- `flush` only gates acceptance. It does not cancel an operation already in flight (the instruction has left EX).
- HI/LO outputs are registered. The new value is visible the cycle after the commit edge; there is no internal bypass.

Optional Feature:
- Macro MD_UNIT_ACC_EN.
- Defined: op 110 MADD: {hi,lo} <= {hi,lo} + signed(a)*signed(b). Op 111 MSUB: {hi,lo} <= {hi,lo} - signed(a)*signed(b).
  - Latency MULT_CYCLES.
  - Accumulation uses the HI/LO value at commit time. That value cannot change in flight.
- Undefined: ops 110/111 are accepted as no-ops (busy stays 0, HI/LO unchanged). No accumulate adder is synthesised.

Decomposition:
- md_pkg: op-code localparams (MD_MULT … MD_MSUB) and the is_mult/is_div/is_mt classification functions shared with controller and hazardcontrol.
- One sub-module, md_latency_timer: loadable down-counter, outputs `busy` and a `done` pulse, parametrised by counter width.
- Arithmetic stays inline in md_unit.

Test Plan:
- MULT a=0xFFFFFFFF b=0x00000002 -> `busy`=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9(-7) b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1.
- MTLO a=0x1234 with HI=5 -> next cycle lo=0x1234, hi=5, `busy` never 1. Then DIVU a=9 b=0 -> `busy` 10 cycles, hi/lo still 5/0x1234.
- Start MULT, then during `busy` pulse start with op=MTHI a=0xDEAD -> ignored; final hi/lo = MULT result only. Separately, start with `flush`=1 -> `busy` stays 0, hi/lo unchanged.
- Assert reset low in the 3rd busy cycle of a DIV -> hi=lo=0 and `busy`=0 immediately (asynchronously); no update after release.
- (MD_UNIT_ACC_EN) hi=0, lo=10, MADD a=3 b=4 -> lo=22. Then MSUB a=-1 b=30 -> lo=52. Without the macro, the same sequence leaves lo=10.
